// File: rtl/split_gen_pkg.sv
// Shared types and helpers for the split-constraint candidate generator.
package split_gen_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, WAIT_CHK, DONE} state_t;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] width_mask(input logic [4:0] w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/split_lfsr32.sv
// 32-bit Galois LFSR; load takes priority, a zero seed falls back to SEED.
module split_lfsr32
  import split_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2B3D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (seed == 32'd0) ? SEED : seed;
    end else if (adv) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'd0);
    end
  end

endmodule

// File: rtl/split_assign_gen.sv
// Candidate producer for the split checker: streams one masked random value per variable,
// retries on unsat verdicts up to MAX_TRIES. Define SPLIT_GEN_STATS_EN for stat_cand/stat_rej.
module split_assign_gen
  import split_gen_pkg::*;
#(
  parameter int          NUM_VARS  = 150,
  parameter int          MAX_W     = 16,
  parameter int          IDX_W     = 8,
  parameter int          MAX_TRIES = 16,
  parameter logic [31:0] SEED      = 32'hACE1_2B3D
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic [4:0]                     cfg_width,
  input  logic                           seed_load,
  input  logic [31:0]                    seed_in,
  input  logic                           start,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_idx,
  output logic [MAX_W-1:0]               out_data,
  output logic                           out_last,
  input  logic                           chk_valid,
  input  logic                           chk_sat,
  output logic                           busy,
  output logic                           done,
  output logic                           sat,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries
`ifdef SPLIT_GEN_STATS_EN
  ,
  output logic [31:0]                    stat_cand,
  output logic [31:0]                    stat_rej
`endif
);

  localparam int                  TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam int                  AW       = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [AW-1:0]       LAST_IDX = AW'(NUM_VARS - 1);
  localparam logic [IDX_W:0]      NV_EXT   = (IDX_W + 1)'(NUM_VARS);
  localparam logic [TRIES_W-1:0]  TMAX     = TRIES_W'(MAX_TRIES);
  localparam logic [4:0]          MAXW5    = 5'(MAX_W);

  state_t          state, state_nxt;
  logic [AW-1:0]   idx;
  logic            hs;
  logic            idle;
  logic [4:0]      width_tab [NUM_VARS];
  logic [31:0]     lfsr;
  logic [31:0]     mask_w;
  logic            unused_bits;

  assign idle = (state == IDLE);

  split_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load && idle),
    .seed  (seed_in),
    .adv   (hs),
    .state (lfsr)
  );

  // Width table: writable only while idle; out-of-range widths clamp to MAX_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VARS; i++) width_tab[i] <= MAXW5;
    end else if (cfg_we && idle && ({1'b0, cfg_idx} < NV_EXT)) begin
      width_tab[cfg_idx[AW-1:0]] <= (cfg_width == 5'd0 || cfg_width > MAXW5) ? MAXW5 : cfg_width;
    end
  end

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = EMIT;
      EMIT: begin
        hs = out_ready;
        if (out_ready && idx == LAST_IDX) state_nxt = WAIT_CHK;
      end
      WAIT_CHK: if (chk_valid) state_nxt = (chk_sat || tries == TMAX) ? DONE : EMIT;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      tries <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx   <= '0;
          tries <= TRIES_W'(1);
          sat   <= 1'b0;
        end
        EMIT: if (hs) idx <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
        WAIT_CHK: if (chk_valid) begin
          if (chk_sat)           sat   <= 1'b1;
          else if (tries != TMAX) tries <= tries + TRIES_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Data is gated by valid so every output reads zero outside EMIT
  assign mask_w    = width_mask(width_tab[idx]);
  assign out_valid = (state == EMIT);
  assign out_idx   = IDX_W'(idx);
  assign out_data  = out_valid ? (lfsr[MAX_W-1:0] & mask_w[MAX_W-1:0]) : '0;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign busy      = !idle;
  assign done      = (state == DONE);

  assign unused_bits = ^{lfsr[31:MAX_W], mask_w[31:MAX_W]};

`ifdef SPLIT_GEN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cand <= '0;
      stat_rej  <= '0;
    end else begin
      if (hs && idx == LAST_IDX && stat_cand != 32'hFFFF_FFFF) stat_cand <= stat_cand + 32'd1;
      if (state == WAIT_CHK && chk_valid && !chk_sat && stat_rej != 32'hFFFF_FFFF)
        stat_rej <= stat_rej + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_split_assign_gen.sv
// Directed bench for split_assign_gen with NUM_VARS=4, MAX_TRIES=3 (default build, no stats).
module tb_split_assign_gen;

  localparam int NV = 4;
  localparam int MT = 3;
  localparam int IW = 8;
  localparam int MW = 16;
  localparam int TW = $clog2(MT + 1);
  localparam logic [31:0] SEED_V = 32'hACE1_2B3D;

  logic          clk, rst_n;
  logic          cfg_we, seed_load, start, out_valid, out_ready, out_last;
  logic          chk_valid, chk_sat, busy, done, sat;
  logic [IW-1:0] cfg_idx, out_idx;
  logic [4:0]    cfg_width;
  logic [31:0]   seed_in;
  logic [MW-1:0] out_data;
  logic [TW-1:0] tries;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_lfsr;
  logic [4:0]  m_w [NV];

  split_assign_gen #(
    .NUM_VARS(NV), .MAX_W(MW), .IDX_W(IW), .MAX_TRIES(MT), .SEED(SEED_V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_width(cfg_width),
    .seed_load(seed_load), .seed_in(seed_in), .start(start), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .chk_valid(chk_valid), .chk_sat(chk_sat), .busy(busy), .done(done), .sat(sat),
    .tries(tries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    logic [31:0] m;
    m = (32'd1 << m_w[i]) - 32'd1;
    return {16'h0, m_lfsr[15:0]} & m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic emit_candidate(input string tag);
    for (int i = 0; i < NV; i++) begin
      check({tag, "_idx"}, 32'(out_idx), 32'(i));
      check({tag, "_data"}, 32'(out_data), exp_data(i));
      check({tag, "_last"}, 32'(out_last), 32'(i == NV - 1));
      step();
      m_lfsr = galois(m_lfsr);
    end
    check({tag, "_wait_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_wait_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic verdict(input logic s);
    chk_valid = 1'b1;
    chk_sat   = s;
    step();
    chk_valid = 1'b0;
    chk_sat   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_width = '0; seed_load = 1'b0;
    seed_in = '0; start = 1'b0; out_ready = 1'b0; chk_valid = 1'b0; chk_sat = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_tries", 32'(tries), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    step();

    // Widths {4,1,0->16,8}; an out-of-range index write is dropped
    cfg_we = 1'b1;
    cfg_idx = 8'd0; cfg_width = 5'd4; step();
    cfg_idx = 8'd1; cfg_width = 5'd1; step();
    cfg_idx = 8'd2; cfg_width = 5'd0; step();
    cfg_idx = 8'd3; cfg_width = 5'd8; step();
    cfg_idx = 8'd4; cfg_width = 5'd3; step();
    cfg_we = 1'b0;
    m_w[0] = 5'd4; m_w[1] = 5'd1; m_w[2] = 5'd16; m_w[3] = 5'd8;

    // Seed load and start together: solve must use seed 1
    seed_in = 32'd1; seed_load = 1'b1; start = 1'b1;
    step();
    seed_load = 1'b0; start = 1'b0; out_ready = 1'b1;
    m_lfsr = 32'd1;
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_tries", 32'(tries), 32'd1);
    check("s1_valid", 32'(out_valid), 32'd1);
    check("beat0_idx", 32'(out_idx), 32'd0);
    check("beat0_data", 32'(out_data), 32'h1);
    step(); m_lfsr = galois(m_lfsr);
    check("beat1_idx", 32'(out_idx), 32'd1);
    check("beat1_data", 32'(out_data), 32'h1);
    step(); m_lfsr = galois(m_lfsr);
    check("beat2_data", 32'(out_data), 32'h2);

    // Stall at idx 2 while pulsing inputs that must be ignored
    out_ready = 1'b0;
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 8'd0; cfg_width = 5'd1;
    seed_load = 1'b1; seed_in = 32'd5; chk_valid = 1'b1; chk_sat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      start = 1'b0; cfg_we = 1'b0; seed_load = 1'b0; chk_valid = 1'b0; chk_sat = 1'b0;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd2);
      check("stall_data", 32'(out_data), 32'h2);
    end
    out_ready = 1'b1;
    check("release_data", 32'(out_data), 32'h2);
    step(); m_lfsr = galois(m_lfsr);
    check("beat3_idx", 32'(out_idx), 32'd3);
    check("beat3_data", 32'(out_data), 32'h01);
    check("beat3_last", 32'(out_last), 32'd1);
    step(); m_lfsr = galois(m_lfsr);
    check("wait_valid", 32'(out_valid), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("wait_hold", 32'({busy, out_valid, done}), 32'b100);
    end

    // Unsat, unsat, sat
    verdict(1'b0);
    check("c2_tries", 32'(tries), 32'd2);
    check("c2_beat0_hand", 32'(out_data), 32'h3);
    emit_candidate("c2");
    verdict(1'b0);
    check("c3_tries", 32'(tries), 32'd3);
    emit_candidate("c3");
    verdict(1'b1);
    check("sat_done", 32'(done), 32'd1);
    check("sat_sat", 32'(sat), 32'd1);
    check("sat_tries", 32'(tries), 32'd3);
    step();
    check("sat_idle_done", 32'(done), 32'd0);
    check("sat_idle_busy", 32'(busy), 32'd0);
    check("sat_held", 32'(sat), 32'd1);

    // Three unsat verdicts exhaust the retry budget
    start = 1'b1; step(); start = 1'b0;
    check("s2_sat_clr", 32'(sat), 32'd0);
    check("s2_tries", 32'(tries), 32'd1);
    emit_candidate("s2c1");
    verdict(1'b0);
    emit_candidate("s2c2");
    verdict(1'b0);
    emit_candidate("s2c3");
    verdict(1'b0);
    check("unsat_done", 32'(done), 32'd1);
    check("unsat_sat", 32'(sat), 32'd0);
    check("unsat_tries", 32'(tries), 32'd3);
    step();
    check("unsat_idle", 32'({busy, done}), 32'b00);

    // Verdict while idle has no effect
    chk_valid = 1'b1; chk_sat = 1'b1; step(); chk_valid = 1'b0; chk_sat = 1'b0;
    check("idle_chk_busy", 32'(busy), 32'd0);
    check("idle_chk_sat", 32'(sat), 32'd0);

    // Reset while waiting for a verdict
    start = 1'b1; step(); start = 1'b0;
    emit_candidate("s3");
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({busy, out_valid, done, sat}), 32'd0);
    check("mid_rst_tries", 32'(tries), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    m_lfsr = SEED_V;
    for (int i = 0; i < NV; i++) m_w[i] = 5'd16;
    start = 1'b1; step(); start = 1'b0;
    check("replay_beat0", 32'(out_data), 32'h2B3D);
    step();
    check("replay_beat1", 32'(out_data), 32'h959D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
